// File: rtl/delay_credit_buffer_if.sv
// Issue, delay-line return and output stream signals of delay_credit_buffer.
// The master modport is the buffer side; slave is the surrounding upstream/downstream logic.
interface delay_credit_buffer_if #(
  parameter int unsigned DATAWIDTH = 32
);
  logic                 issue_ready;
  logic                 issue_fire;
  logic                 pipe_valid;
  logic [DATAWIDTH-1:0] pipe_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATAWIDTH-1:0] m_data;

  modport master (
    output issue_ready, m_valid, m_data,
    input  issue_fire, pipe_valid, pipe_data, m_ready
  );

  modport slave (
    input  issue_ready, m_valid, m_data,
    output issue_fire, pipe_valid, pipe_data, m_ready
  );
endinterface

// File: rtl/delay_credit_buffer.sv
// Credit-managed FIFO behind a fixed-latency, non-stallable delay line.
// Define DELAY_CREDIT_BUFFER_BYPASS_EN to present a word arriving at an empty FIFO combinationally.
module delay_credit_buffer #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned DEPTH     = LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  delay_credit_buffer_if.master bus,
  output logic                  credit_err,
  output logic                  overflow_err
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]        credits_q, credits_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic                 credit_err_q, credit_err_d;
  logic                 overflow_err_q, overflow_err_d;
  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  logic                 byp;
  logic                 take;
  logic                 pop;
  logic                 byp_take;
  logic                 fifo_pop;
  logic                 push;
  logic                 m_valid_c;
  logic [DATAWIDTH-1:0] m_data_c;

  // Per-cycle events and next state; a bypassed word consumed at once never touches the FIFO.
  always_comb begin
    byp            = 1'b0;
`ifdef DELAY_CREDIT_BUFFER_BYPASS_EN
    byp            = (count_q == '0) && bus.pipe_valid;
`endif
    m_valid_c      = (count_q != '0) || byp;
    m_data_c       = byp ? bus.pipe_data : mem_q[rd_ptr_q];
    take           = bus.issue_fire && (credits_q != '0);
    pop            = m_valid_c && bus.m_ready;
    byp_take       = byp && bus.m_ready;
    fifo_pop       = pop && !byp_take;
    push           = bus.pipe_valid && !byp_take && ((count_q < CW'(DEPTH)) || pop);

    credits_d      = credits_q - CW'(take) + CW'(pop);
    count_d        = count_q + CW'(push) - CW'(fifo_pop);
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    if (push)
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (fifo_pop)
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    credit_err_d   = credit_err_q || (bus.issue_fire && (credits_q == '0));
    overflow_err_d = overflow_err_q || (bus.pipe_valid && !push && !byp_take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q      <= CW'(DEPTH);
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      credit_err_q   <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      credits_q      <= credits_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      credit_err_q   <= credit_err_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wr_ptr_q] <= bus.pipe_data;
  end

  assign bus.issue_ready = (credits_q != '0);
  assign bus.m_valid     = m_valid_c;
  assign bus.m_data      = m_data_c;
  assign credit_err      = credit_err_q;
  assign overflow_err    = overflow_err_q;

`ifndef SYNTHESIS
  // Every credit is either free, parked in the FIFO, or riding the delay line.
  int inflight_q, inflight_d;

  always_comb begin
    inflight_d = inflight_q + int'(take) - int'(bus.pipe_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= 0;
    else     inflight_q <= inflight_d;
    if (!rst && !overflow_err_q) begin
      assert (int'(credits_q) + int'(count_q) + inflight_q == int'(DEPTH));
      assert (inflight_q <= int'(LATENCY));
    end
  end
`endif
endmodule
